// File: rtl/snake_game_ctrl.sv
// Snake game controller: game FSM, move timing, scoring, lives and level tracking.
// Optional pause support is compiled in when SNAKE_PAUSE_EN is defined.
module snake_game_ctrl #(
    parameter int SCORE_W          = 8,
    parameter int LIVES            = 3,
    parameter int START_PERIOD     = 30,
    parameter int MIN_PERIOD       = 4,
    parameter int PERIOD_STEP      = 2,
    parameter int APPLES_PER_LEVEL = 5,
    parameter int MAX_LEVEL        = 15,
    parameter int DYING_FRAMES     = 60,
    parameter int GAME_OVER_FRAMES = 120
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               up,
    input  logic               down,
    input  logic               left,
    input  logic               right,
    input  logic               pause,
    input  logic [1:0]         collision_state,
    output logic [2:0]         game_state,
    output logic               move_tick,
    output logic               apple_trigger,
    output logic               respawn,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic [2:0]         lives,
    output logic [3:0]         level
);

    localparam logic [2:0] S_IDLE  = 3'b000;
    localparam logic [2:0] S_PLAY  = 3'b001;
    localparam logic [2:0] S_PAUSE = 3'b010;
    localparam logic [2:0] S_DYING = 3'b011;
    localparam logic [2:0] S_OVER  = 3'b111;

    localparam int FC_MAX = (START_PERIOD > MIN_PERIOD) ? START_PERIOD : MIN_PERIOD;
    localparam int FC_W   = $clog2(FC_MAX + 1);
    localparam int ST_MAX = (DYING_FRAMES > GAME_OVER_FRAMES) ? DYING_FRAMES : GAME_OVER_FRAMES;
    localparam int ST_W   = $clog2(ST_MAX + 1);
    localparam int AC_W   = $clog2(APPLES_PER_LEVEL + 1);

    logic [2:0]      state;
    logic [FC_W-1:0] frame_cnt;
    logic [FC_W-1:0] period_m1;
    logic [ST_W-1:0] state_cnt;
    logic [AC_W-1:0] apple_cnt;
    logic            apple_prev;
    logic            any_btn;
    logic            in_play;
    logic            collide;
    logic            apple_evt;
    logic            pause_rise;
    int              period;

    // Signed arithmetic keeps the subtraction from wrapping at high levels.
    always_comb begin
        period = START_PERIOD - int'(level) * PERIOD_STEP;
        if (period < MIN_PERIOD)
            period = MIN_PERIOD;
        period_m1 = FC_W'(period - 1);
    end

    assign game_state = state;
    assign any_btn    = up | down | left | right;
    assign in_play    = (state == S_PLAY);
    // The 2-bit encoding makes collision and apple mutually exclusive in one cycle;
    // collision is still tested first so it always takes priority.
    assign collide    = in_play && (collision_state == 2'b01);
    assign apple_evt  = in_play && (collision_state == 2'b10) && !apple_prev;
    // >= rather than == so a period that shrinks below the current count still fires.
    assign move_tick  = in_play && frame_tick && (frame_cnt >= period_m1);

`ifdef SNAKE_PAUSE_EN
    logic pause_prev;
    assign pause_rise = pause & ~pause_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pause_prev <= 1'b0;
        else
            pause_prev <= pause;
    end
`else
    logic unused_pause;
    assign unused_pause = pause;
    assign pause_rise   = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            frame_cnt     <= '0;
            state_cnt     <= '0;
            apple_cnt     <= '0;
            apple_prev    <= 1'b0;
            score         <= '0;
            high_score    <= '0;
            level         <= '0;
            lives         <= 3'(LIVES);
            apple_trigger <= 1'b0;
            respawn       <= 1'b0;
        end else begin
            apple_trigger <= 1'b0;
            respawn       <= 1'b0;
            apple_prev    <= (collision_state == 2'b10);
            case (state)
                S_IDLE: begin
                    if (any_btn) begin
                        state     <= S_PLAY;
                        score     <= '0;
                        level     <= '0;
                        apple_cnt <= '0;
                        frame_cnt <= '0;
                        state_cnt <= '0;
                        lives     <= 3'(LIVES);
                    end
                end
                S_PLAY: begin
                    if (collide) begin
                        lives     <= lives - 3'd1;
                        state_cnt <= '0;
                        if (lives == 3'd1) begin
                            state <= S_OVER;
                            if (score > high_score)
                                high_score <= score;
                        end else begin
                            state <= S_DYING;
                        end
                    end else begin
                        if (apple_evt) begin
                            apple_trigger <= 1'b1;
                            if (score != {SCORE_W{1'b1}})
                                score <= score + 1'b1;
                            if (apple_cnt == AC_W'(APPLES_PER_LEVEL - 1)) begin
                                apple_cnt <= '0;
                                if (level != 4'(MAX_LEVEL))
                                    level <= level + 4'd1;
                            end else begin
                                apple_cnt <= apple_cnt + 1'b1;
                            end
                        end
                        if (frame_tick)
                            frame_cnt <= move_tick ? '0 : frame_cnt + 1'b1;
                        if (pause_rise)
                            state <= S_PAUSE;
                    end
                end
`ifdef SNAKE_PAUSE_EN
                S_PAUSE: begin
                    if (pause_rise)
                        state <= S_PLAY;
                end
`endif
                S_DYING: begin
                    if (frame_tick) begin
                        if (state_cnt == ST_W'(DYING_FRAMES - 1)) begin
                            state     <= S_PLAY;
                            respawn   <= 1'b1;
                            frame_cnt <= '0;
                            state_cnt <= '0;
                        end else begin
                            state_cnt <= state_cnt + 1'b1;
                        end
                    end
                end
                S_OVER: begin
                    if (frame_tick) begin
                        if (state_cnt == ST_W'(GAME_OVER_FRAMES - 1)) begin
                            state     <= S_IDLE;
                            state_cnt <= '0;
                        end else begin
                            state_cnt <= state_cnt + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl with hand-computed expectations.
// The pause scenario follows the same SNAKE_PAUSE_EN macro as the design.
module tb_snake_game_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       up, down, left, right;
    logic       pause;
    logic [1:0] collision_state;
    logic [2:0] game_state;
    logic       move_tick, apple_trigger, respawn;
    logic [7:0] score, high_score;
    logic [2:0] lives;
    logic [3:0] level;

    int n_chk = 0;
    int n_err = 0;
    int mv_cnt = 0;
    int apl_cnt = 0;
    int rsp_cnt = 0;

    snake_game_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .frame_tick      (frame_tick),
        .up              (up),
        .down            (down),
        .left            (left),
        .right           (right),
        .pause           (pause),
        .collision_state (collision_state),
        .game_state      (game_state),
        .move_tick       (move_tick),
        .apple_trigger   (apple_trigger),
        .respawn         (respawn),
        .score           (score),
        .high_score      (high_score),
        .lives           (lives),
        .level           (level)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (move_tick)     mv_cnt  = mv_cnt + 1;
        if (apple_trigger) apl_cnt = apl_cnt + 1;
        if (respawn)       rsp_cnt = rsp_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            tick();
            frame_tick = 1'b0;
            tick();
        end
    endtask

    task automatic apples(input int n);
        for (int i = 0; i < n; i++) begin
            collision_state = 2'b10;
            tick(); tick(); tick();
            collision_state = 2'b00;
            tick();
        end
    endtask

    task automatic collide();
        collision_state = 2'b01;
        tick();
        collision_state = 2'b00;
        tick();
    endtask

    task automatic press_right();
        right = 1'b1;
        tick();
        right = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; up = 1'b0; down = 1'b0; left = 1'b0;
        right = 1'b0; pause = 1'b0; collision_state = 2'b00;
        tick(); tick();
        chk("rst_state", game_state, 0);
        chk("rst_lives", lives, 3);
        chk("rst_score", score, 0);
        chk("rst_high", high_score, 0);
        chk("rst_move", move_tick, 0);
        reset = 1'b0;
        tick();
        chk("idle_hold", game_state, 0);

        // Game A: start, base move period, five apples, level-up, deaths.
        press_right();
        chk("a_state", game_state, 1);
        chk("a_lives", lives, 3);
        chk("a_score", score, 0);
        mv_cnt = 0;
        frames(29);
        chk("a_mv29", mv_cnt, 0);
        frames(1);
        chk("a_mv30", mv_cnt, 1);
        frames(30);
        chk("a_mv60", mv_cnt, 2);

        apl_cnt = 0;
        collision_state = 2'b10;
        tick();
        chk("a_trig_next", apple_trigger, 1);
        chk("a_score1", score, 1);
        tick();
        chk("a_trig_once", apple_trigger, 0);
        tick();
        collision_state = 2'b00;
        tick();
        apples(4);
        chk("a_score5", score, 5);
        chk("a_trig5", apl_cnt, 5);
        chk("a_level1", level, 1);
        mv_cnt = 0;
        frames(27);
        chk("a_l1_mv27", mv_cnt, 0);
        frames(1);
        chk("a_l1_mv28", mv_cnt, 1);

        collision_state = 2'b11;
        tick();
        collision_state = 2'b00;
        tick();
        chk("a_cs11_lives", lives, 3);
        chk("a_cs11_state", game_state, 1);

        // Collision, then an apple edge while already dying: the apple is ignored.
        apl_cnt = 0;
        collision_state = 2'b01;
        tick();
        collision_state = 2'b10;
        tick();
        collision_state = 2'b00;
        tick();
        chk("a_die_state", game_state, 3);
        chk("a_die_lives", lives, 2);
        chk("a_die_score", score, 5);
        chk("a_die_trig", apl_cnt, 0);
        mv_cnt = 0; rsp_cnt = 0;
        frames(59);
        chk("a_dying59", game_state, 3);
        chk("a_rsp59", rsp_cnt, 0);
        chk("a_dying_mv", mv_cnt, 0);
        frames(1);
        chk("a_resp_state", game_state, 1);
        chk("a_rsp60", rsp_cnt, 1);
        chk("a_resp_score", score, 5);
        chk("a_resp_level", level, 1);
        mv_cnt = 0;
        frames(28);
        chk("a_resp_mv", mv_cnt, 1);

        collide();
        chk("a_lives1", lives, 1);
        frames(60);
        collide();
        chk("a_over", game_state, 7);
        chk("a_over_lives", lives, 0);
        chk("a_high5", high_score, 5);
        frames(119);
        press_right();
        chk("a_over_btn", game_state, 7);
        frames(1);
        chk("a_idle", game_state, 0);

        // Game B: lower score must not replace the high score.
        press_right();
        chk("b_state", game_state, 1);
        chk("b_score", score, 0);
        chk("b_level", level, 0);
        chk("b_lives", lives, 3);
        apples(3);
        chk("b_score3", score, 3);
        collide(); frames(60);
        collide(); frames(60);
        collide();
        chk("b_over", game_state, 7);
        chk("b_high_keep", high_score, 5);
        frames(120);
        chk("b_idle", game_state, 0);

        // Game C: score 7 on final death beats high score 5.
        press_right();
        apples(7);
        chk("c_score7", score, 7);
        chk("c_level1", level, 1);
        collide(); frames(60);
        collide(); frames(60);
        chk("c_lives1", lives, 1);
        collide();
        chk("c_over", game_state, 7);
        chk("c_high7", high_score, 7);
        frames(120);
        chk("c_idle", game_state, 0);

        // Game D: pause, saturation, asynchronous reset mid-game.
        press_right();
        mv_cnt = 0;
        frames(10);
        pause = 1'b1;
        tick(); tick();
`ifdef SNAKE_PAUSE_EN
        chk("d_paused", game_state, 2);
        frames(100);
        chk("d_pause_mv", mv_cnt, 0);
        collide();
        chk("d_pause_lives", lives, 3);
        pause = 1'b0;
        tick();
        pause = 1'b1;
        tick();
        chk("d_resumed", game_state, 1);
`else
        chk("d_nopause", game_state, 1);
`endif
        pause = 1'b0;
        tick();
        frames(19);
        chk("d_mv29", mv_cnt, 0);
        frames(1);
        chk("d_mv30", mv_cnt, 1);

        apples(256);
        chk("d_score_sat", score, 255);
        chk("d_level_sat", level, 15);
        mv_cnt = 0;
        frames(3);
        chk("d_min_mv3", mv_cnt, 0);
        frames(1);
        chk("d_min_mv4", mv_cnt, 1);

        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("d_rst_state", game_state, 0);
        chk("d_rst_score", score, 0);
        chk("d_rst_high", high_score, 0);
        chk("d_rst_level", level, 0);
        chk("d_rst_lives", lives, 3);
        tick();
        reset = 1'b0;
        tick();
        chk("d_rst_idle", game_state, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
